// File: rtl/gpu_cmd_pkg.sv
// Shared opcode constants and FSM state encoding for the GPU command decoder.
package gpu_cmd_pkg;

  localparam logic [7:0] OpSetP1   = 8'h01;
  localparam logic [7:0] OpSetP2   = 8'h02;
  localparam logic [7:0] OpSetSize = 8'h03;
  localparam logic [7:0] OpFill    = 8'h04;
  localparam logic [7:0] OpBlit    = 8'h05;
  localparam logic [7:0] OpStatus  = 8'h06;

  typedef enum logic [2:0] {
    StIdle,
    StPayload,
    StIssue,
    StWait,
    StStatus
  } state_e;

endpackage

// File: rtl/gpu_command_decoder.sv
// Decodes the host command byte stream into GPU operand registers and start pulses,
// and answers STATUS requests on the outbound byte stream.
module gpu_command_decoder
  import gpu_cmd_pkg::*;
#(
  parameter int unsigned WIDTH  = 320,
  parameter int unsigned HEIGHT = 200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  input  logic       out_ready,
  output logic [8:0] X1,
  output logic [7:0] Y1,
  output logic [8:0] X2,
  output logic [7:0] Y2,
  output logic [8:0] blit_x_width,
  output logic [7:0] blit_y_height,
  output logic       fill_value,
  output logic       start_fill,
  output logic       start_blit,
  input  logic       gpu_busy,
  input  logic       gpu_error,
  output logic       bad_cmd
);

  state_e     state_q;
  logic [1:0] cnt_q;
  logic [7:0] op_q;
  logic [7:0] b0_q;
  logic       b1_bit_q;
  logic       op_fill_q;
  logic       last_error_q;

  logic [1:0] last_idx;
  logic [8:0] pay_w;
  logic       size_ok;

  always_comb begin
    last_idx = (op_q == OpFill) ? 2'd0 : 2'd2;
    pay_w    = {b1_bit_q, b0_q};
    size_ok  = (pay_w != 9'd0) && ({23'd0, pay_w} <= WIDTH) &&
               (in_data != 8'd0) && ({24'd0, in_data} <= HEIGHT);
  end

  assign in_ready  = (state_q == StIdle) || (state_q == StPayload);
  assign out_valid = (state_q == StStatus);
  assign out_data  = (state_q == StStatus) ? {5'b0, bad_cmd, last_error_q, gpu_busy} : 8'h00;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      cnt_q         <= 2'd0;
      op_q          <= 8'h00;
      b0_q          <= 8'h00;
      b1_bit_q      <= 1'b0;
      op_fill_q     <= 1'b0;
      last_error_q  <= 1'b0;
      X1            <= 9'd0;
      Y1            <= 8'd0;
      X2            <= 9'd0;
      Y2            <= 8'd0;
      blit_x_width  <= 9'd1;
      blit_y_height <= 8'd1;
      fill_value    <= 1'b0;
      start_fill    <= 1'b0;
      start_blit    <= 1'b0;
      bad_cmd       <= 1'b0;
    end else begin
      start_fill <= 1'b0;
      start_blit <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            cnt_q <= 2'd0;
            op_q  <= in_data;
            case (in_data)
              OpSetP1, OpSetP2, OpSetSize, OpFill: state_q <= StPayload;
              OpBlit: begin
                op_fill_q <= 1'b0;
                state_q   <= StIssue;
              end
              OpStatus: state_q <= StStatus;
              default:  bad_cmd <= 1'b1;
            endcase
          end
        end
        StPayload: begin
          if (in_valid) begin
            if (cnt_q == last_idx) begin
              cnt_q   <= 2'd0;
              state_q <= StIdle;
              case (op_q)
                OpSetP1: begin
                  X1 <= pay_w;
                  Y1 <= in_data;
                end
                OpSetP2: begin
                  X2 <= pay_w;
                  Y2 <= in_data;
                end
                OpSetSize: begin
                  if (size_ok) begin
                    blit_x_width  <= pay_w;
                    blit_y_height <= in_data;
                  end else begin
                    bad_cmd <= 1'b1;
                  end
                end
                OpFill: begin
                  fill_value <= in_data[0];
                  op_fill_q  <= 1'b1;
                  state_q    <= StIssue;
                end
                default: state_q <= StIdle;
              endcase
            end else begin
              cnt_q <= cnt_q + 2'd1;
              if (cnt_q == 2'd0) begin
                b0_q <= in_data;
              end else begin
                b1_bit_q <= in_data[0];
              end
            end
          end
        end
        StIssue: begin
          if (!gpu_busy) begin
            if (op_fill_q) begin
              start_fill <= 1'b1;
            end else begin
              start_blit <= 1'b1;
            end
            state_q <= StWait;
          end
        end
        StWait: begin
          // The GPU may not raise busy until after the pulse, so skip the pulse cycle.
          if (!(start_fill || start_blit) && !gpu_busy) begin
            last_error_q <= gpu_error;
            state_q      <= StIdle;
          end
        end
        StStatus: begin
          if (out_ready) begin
            bad_cmd <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_gpu_command_decoder.sv
// Self-checking bench: a command-level model predicts every output each cycle,
// plus literal checks on the directed command scenarios.
module tb_gpu_command_decoder;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic [8:0] X1, X2, blit_x_width;
  logic [7:0] Y1, Y2, blit_y_height;
  logic       fill_value, start_fill, start_blit;
  logic       gpu_busy, gpu_error, bad_cmd;

  logic busy_force;
  int   busy_len;
  int   busy_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int fill_pulses = 0;
  int blit_pulses = 0;

  gpu_command_decoder #(
    .WIDTH (320),
    .HEIGHT(200)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_ready    (out_ready),
    .X1           (X1),
    .Y1           (Y1),
    .X2           (X2),
    .Y2           (Y2),
    .blit_x_width (blit_x_width),
    .blit_y_height(blit_y_height),
    .fill_value   (fill_value),
    .start_fill   (start_fill),
    .start_blit   (start_blit),
    .gpu_busy     (gpu_busy),
    .gpu_error    (gpu_error),
    .bad_cmd      (bad_cmd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // GPU stand-in: after a start pulse, report busy for busy_len cycles.
  assign gpu_busy = busy_force || (busy_cnt > 0);
  initial begin
    busy_cnt = 0;
    forever begin
      @(negedge clk);
      if (busy_cnt > 0) busy_cnt = busy_cnt - 1;
      if ((start_fill || start_blit) && busy_len > 0) busy_cnt = busy_len;
    end
  end

  // ---------------- command-level model ----------------
  logic [7:0] m_cmd[$];
  int m_x1, m_y1, m_x2, m_y2, m_w, m_h, m_fill, m_bad, m_lerr;
  int m_pending;  // 0 none, 1 fill queued, 2 blit queued
  bit m_running, m_skip, m_status, m_sf, m_sb;

  function automatic int payload_len(input logic [7:0] op);
    case (op)
      8'h01, 8'h02, 8'h03: return 3;
      8'h04:               return 1;
      8'h05, 8'h06:        return 0;
      default:             return -1;
    endcase
  endfunction

  task automatic model_reset();
    m_cmd.delete();
    m_x1 = 0; m_y1 = 0; m_x2 = 0; m_y2 = 0; m_w = 1; m_h = 1;
    m_fill = 0; m_bad = 0; m_lerr = 0; m_pending = 0;
    m_running = 0; m_skip = 0; m_status = 0; m_sf = 0; m_sb = 0;
  endtask

  task automatic model_exec();
    logic [7:0] op, a, b, c;
    int xv;
    op = m_cmd[0];
    a = (m_cmd.size() > 1) ? m_cmd[1] : 8'h00;
    b = (m_cmd.size() > 2) ? m_cmd[2] : 8'h00;
    c = (m_cmd.size() > 3) ? m_cmd[3] : 8'h00;
    xv = int'(a) + (b[0] ? 256 : 0);
    case (op)
      8'h01: begin m_x1 = xv; m_y1 = int'(c); end
      8'h02: begin m_x2 = xv; m_y2 = int'(c); end
      8'h03: begin
        if (xv >= 1 && xv <= 320 && c >= 1 && c <= 200) begin
          m_w = xv; m_h = int'(c);
        end else begin
          m_bad = 1;
        end
      end
      8'h04: begin m_fill = a[0] ? 1 : 0; m_pending = 1; end
      8'h05: m_pending = 2;
      8'h06: m_status = 1;
      default: ;
    endcase
  endtask

  task automatic model_step();
    int need;
    if (rst) begin
      model_reset();
      return;
    end
    m_sf = 0;
    m_sb = 0;
    if (m_status) begin
      if (out_ready) begin m_bad = 0; m_status = 0; end
    end else if (m_pending != 0) begin
      if (!gpu_busy) begin
        if (m_pending == 1) m_sf = 1; else m_sb = 1;
        m_pending = 0; m_running = 1; m_skip = 1;
      end
    end else if (m_running) begin
      if (m_skip) m_skip = 0;
      else if (!gpu_busy) begin m_lerr = gpu_error ? 1 : 0; m_running = 0; end
    end else if (in_valid) begin
      m_cmd.push_back(in_data);
      need = payload_len(m_cmd[0]);
      if (need < 0) begin
        m_bad = 1;
        m_cmd.delete();
      end else if (m_cmd.size() == need + 1) begin
        model_exec();
        m_cmd.delete();
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      model_step();
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  initial begin
    logic [7:0] e_od;
    forever begin
      @(posedge clk);
      #2;
      if (start_fill) fill_pulses++;
      if (start_blit) blit_pulses++;
      e_od = m_status ? {5'b0, m_bad[0], m_lerr[0], gpu_busy} : 8'h00;
      chk("in_ready", {31'd0, in_ready}, {31'd0, !(m_status || m_pending != 0 || m_running)});
      chk("out_valid", {31'd0, out_valid}, {31'd0, m_status});
      chk("out_data", {24'd0, out_data}, {24'd0, e_od});
      chk("start_fill", {31'd0, start_fill}, {31'd0, m_sf});
      chk("start_blit", {31'd0, start_blit}, {31'd0, m_sb});
      chk("bad_cmd", {31'd0, bad_cmd}, m_bad);
      chk("X1", {23'd0, X1}, m_x1);
      chk("Y1", {24'd0, Y1}, m_y1);
      chk("X2", {23'd0, X2}, m_x2);
      chk("Y2", {24'd0, Y2}, m_y2);
      chk("blit_x_width", {23'd0, blit_x_width}, m_w);
      chk("blit_y_height", {24'd0, blit_y_height}, m_h);
      chk("fill_value", {31'd0, fill_value}, m_fill);
    end
  end

  // ---------------- stimulus ----------------
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("send_timeout", 32'd1, 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_seq(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] c, input logic [7:0] d);
    send_byte(a);
    send_byte(b);
    send_byte(c);
    send_byte(d);
  endtask

  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (!in_ready && cycles < 200) begin
      @(negedge clk);
      cycles++;
    end
    if (cycles >= 200) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic do_status(input logic [7:0] exp);
    int n;
    n = 0;
    send_byte(8'h06);
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("status_valid", {31'd0, out_valid}, 32'd1);
    chk("status_byte", {24'd0, out_data}, {24'd0, exp});
    repeat (2) @(negedge clk);
    chk("status_hold", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, fp0, bp0;
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    busy_force = 1'b0; busy_len = 0; gpu_error = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset_width", {23'd0, blit_x_width}, 32'd1);
    chk("reset_height", {24'd0, blit_y_height}, 32'd1);
    chk("reset_out_data", {24'd0, out_data}, 32'd0);

    // Point set-up
    send_seq(8'h01, 8'h2C, 8'h01, 8'hC7);
    send_seq(8'h02, 8'h3F, 8'h01, 8'hC7);
    chk("p1_x", {23'd0, X1}, 32'd300);
    chk("p1_y", {24'd0, Y1}, 32'd199);
    chk("p2_x", {23'd0, X2}, 32'd319);
    chk("p2_y", {24'd0, Y2}, 32'd199);
    chk("p_bad", {31'd0, bad_cmd}, 32'd0);

    // FILL with a 4-cycle busy GPU
    busy_len = 4;
    fp0 = fill_pulses;
    send_byte(8'h04);
    send_byte(8'hFF);
    wait_idle(cyc);
    chk("fill_busy_cycles", cyc, 32'd6);
    chk("fill_pulses", fill_pulses - fp0, 32'd1);
    chk("fill_value", {31'd0, fill_value}, 32'd1);
    busy_len = 0;

    // Illegal sizes, then STATUS, then the legal maximum size
    send_seq(8'h03, 8'h00, 8'h00, 8'h0A);
    send_seq(8'h03, 8'h41, 8'h01, 8'h0A);
    chk("size_bad", {31'd0, bad_cmd}, 32'd1);
    chk("size_w_kept", {23'd0, blit_x_width}, 32'd1);
    chk("size_h_kept", {24'd0, blit_y_height}, 32'd1);
    do_status(8'h04);
    chk("status_clears_bad", {31'd0, bad_cmd}, 32'd0);
    send_seq(8'h03, 8'h40, 8'h01, 8'hC8);
    chk("size_w_max", {23'd0, blit_x_width}, 32'd320);
    chk("size_h_max", {24'd0, blit_y_height}, 32'd200);
    chk("size_max_ok", {31'd0, bad_cmd}, 32'd0);

    // BLIT held off by a busy GPU, with an error reported at completion
    @(negedge clk);
    busy_force = 1'b1;
    gpu_error = 1'b1;
    bp0 = blit_pulses;
    send_byte(8'h05);
    repeat (3) @(negedge clk);
    chk("blit_held", blit_pulses - bp0, 32'd0);
    busy_force = 1'b0;
    wait_idle(cyc);
    chk("blit_pulses", blit_pulses - bp0, 32'd1);
    gpu_error = 1'b0;
    do_status(8'h02);

    // Unknown opcode, then reset in the middle of a SET_P1
    fp0 = fill_pulses;
    bp0 = blit_pulses;
    send_byte(8'h7F);
    chk("bad_opcode", {31'd0, bad_cmd}, 32'd1);
    repeat (3) @(negedge clk);
    chk("bad_no_pulse", (fill_pulses - fp0) + (blit_pulses - bp0), 32'd0);
    send_byte(8'h01);
    send_byte(8'h2C);
    #2 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_mid_bad", {31'd0, bad_cmd}, 32'd0);
    send_seq(8'h01, 8'h00, 8'h00, 8'h05);
    chk("after_rst_x1", {23'd0, X1}, 32'd0);
    chk("after_rst_y1", {24'd0, Y1}, 32'd5);
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
